// File: rtl/fpu_mul_result_queue_if.sv
// rtl/fpu_mul_result_queue_if.sv - producer/consumer handshake bundle for the FP32 multiplier result queue
interface fpu_mul_result_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_error;
    logic        out_overflow;
    logic [2:0]  out_class;

    modport master (
        output in_valid, in_result, in_error, in_overflow, out_ready,
        input  in_ready, out_valid, out_result, out_error, out_overflow, out_class
    );

    modport slave (
        input  in_valid, in_result, in_error, in_overflow, out_ready,
        output in_ready, out_valid, out_result, out_error, out_overflow, out_class
    );
endinterface

// File: rtl/fpu_mul_result_queue.sv
// rtl/fpu_mul_result_queue.sv - classifying FIFO with sticky status for FP32 multiplier products
module fpu_mul_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fpu_mul_result_queue_if.slave    q,
    input  logic                     clear_flags,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     flag_error_sticky,
    output logic                     flag_overflow_sticky,
    output logic [CNT_W-1:0]         err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Entry layout: {result[31:0], error, overflow, class[2:0]}
    logic [36:0]      mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ferr_q, ferr_d;
    logic             fovf_q, fovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    logic [36:0]      head;

    // IEEE-754 class of a product word; the sign bit is deliberately ignored
    function automatic logic [2:0] classify(input logic [31:0] w);
        logic exp_zero, exp_ones, frac_zero;
        exp_zero  = (w[30:23] == 8'h00);
        exp_ones  = (w[30:23] == 8'hFF);
        frac_zero = (w[22:0] == 23'd0);
        if (exp_zero)      classify = frac_zero ? 3'b001 : 3'b100;
        else if (exp_ones) classify = frac_zero ? 3'b010 : 3'b011;
        else               classify = 3'b000;
    endfunction

    assign q.in_ready  = (count_q != FULL_CNT);
    assign q.out_valid = (count_q != '0);
    assign push        = q.in_valid & q.in_ready;
    assign pop         = q.out_valid & q.out_ready;
    assign occupancy   = count_q;

    // Outputs come only from stored entries, forced to zero when the queue is empty
    assign head           = q.out_valid ? mem_q[rptr_q] : '0;
    assign q.out_result   = head[36:5];
    assign q.out_error    = head[4];
    assign q.out_overflow = head[3];
    assign q.out_class    = head[2:0];

    assign flag_error_sticky    = ferr_q;
    assign flag_overflow_sticky = fovf_q;
    assign err_count            = cnt_q;

    // Entry storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {q.in_result, q.in_error, q.in_overflow, classify(q.in_result)};
        end
    end

    // Next-state for pointers, occupancy and status; a setting push beats a same-cycle clear
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ferr_d  = ferr_q;
        fovf_d  = fovf_q;
        cnt_d   = cnt_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (clear_flags) begin
            ferr_d = push & q.in_error;
            fovf_d = push & q.in_overflow;
            cnt_d  = (push & q.in_error) ? CNT_ONE : '0;
        end else begin
            ferr_d = ferr_q | (push & q.in_error);
            fovf_d = fovf_q | (push & q.in_overflow);
            if (push && q.in_error && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ferr_q  <= 1'b0;
            fovf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ferr_q  <= ferr_d;
            fovf_q  <= fovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/fpu_mul_result_queue.md
Name: fpu_mul_result_queue

Overview:
- Sits directly downstream of the combinational FP32 multiplier. Captures each product word (resultMul, errorMul, overflowMul) through a valid/ready handshake into a DEPTH-entry FIFO.
- Tags each entry with an IEEE-754 result class and presents entries in order to the writeback/consumer side.
- Keeps sticky error/overflow status flags and a saturating error counter for software polling.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a product this cycle.
- in_ready  output  1  queue can accept; equals (count != DEPTH).
- in_result  input  32  product word from multiplier (resultMul).
- in_error  input  1  multiplier errorMul.
- in_overflow  input  1  multiplier overflowMul.
- out_valid  output  1  head entry available; equals (count != 0).
- out_ready  input  1  consumer takes head this cycle.
- out_result  output  32  head entry product; 0 when empty.
- out_error  output  1  head entry error bit; 0 when empty.
- out_overflow  output  1  head entry overflow bit; 0 when empty.
- out_class  output  3  head entry class; 000 when empty.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- clear_flags  input  1  one-cycle pulse; clears sticky flags and err_count.
- flag_error_sticky  output  1  set by any accepted entry with in_error=1.
- flag_overflow_sticky  output  1  set by any accepted entry with in_overflow=1.
- err_count  output  CNT_W  number of accepted entries with in_error=1; saturating.

Behaviour:
- Reset (rst_n=0 at posedge):
  - count=0; read and write pointers = 0.
  - Sticky flags = 0; err_count = 0.
  - All out_* = 0; in_ready = 1 after reset.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries; no partial state survives.
- Push: in_valid & in_ready at posedge. Write {in_result, in_error, in_overflow, class} at wptr; wptr increments modulo DEPTH.
- Pop: out_valid & out_ready at posedge. rptr increments modulo DEPTH.
- Output timing: out_* are driven from the head entry registers (no combinational path from in_* to out_*).
  - Latency from push to out_valid is 1 cycle.
  - There is no bypass when the queue is empty.
- Full: in_ready=0, even if out_ready=1 in the same cycle. There is no same-cycle pass-through at full.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous push and pop (0<count<DEPTH): both occur and count is unchanged.
- Pointer wrap: the DEPTH-1 -> 0 transition must preserve FIFO order.
- Class is computed at push from in_result; exp=[30:23], frac=[22:0]:
  - 001 zero: exp=0, frac=0.
  - 100 denormal: exp=0, frac!=0.
  - 010 infinity: exp=FF, frac=0.
  - 011 NaN: exp=FF, frac!=0.
  - 000 normal: otherwise.
  - The sign bit does not affect class.
- Sticky flags:
  - On an accepted push with in_error=1, flag_error_sticky <= 1; likewise in_overflow sets flag_overflow_sticky.
  - clear_flags=1 clears both flags.
  - Clear in the same cycle as a setting push: the set wins (flag=1), so no event is lost.
  - Flags are unaffected by pops.
- err_count:
  - Increments on an accepted push with in_error=1.
  - Holds at 2^CNT_W-1 (no wrap).
  - clear_flags alone sets it to 0.
  - Clear in the same cycle as an error push sets it to 1.
- in_valid without in_ready: no state change. The producer holds its data; the queue does not require data to stay stable when in_valid=0.
- occupancy always equals count: range 0..DEPTH.

Test Plan:
- Reset then push 0x40400000 (3.0, err=0, ovf=0) -> next cycle out_valid=1, out_result=0x40400000, out_class=000, occupancy=1; pop with out_ready=1 -> out_valid=0, out_result=0.
- Push 0x7F800000 (err=1, ovf=1), 0x7FC00000 (err=1, ovf=0), 0x80000000, 0x00000001 with out_ready=0 -> in_ready=0 after the 4th push; out_class sequence on draining is 010, 011, 001, 100; flag_error_sticky=1, flag_overflow_sticky=1, err_count=2.
- At full, assert in_valid=1 and out_ready=1 with 0x3F800000 -> only the pop occurs; 0x3F800000 is not accepted that cycle and is accepted the next cycle; order is preserved across pointer wrap.
- At count=2, push and pop together for 10 cycles with incrementing values 0x3F800000+k -> occupancy stays 2; outputs emerge in order with no loss or duplication.
- clear_flags=1 in the same cycle as an accepted push with in_error=1 -> flag_error_sticky=1, err_count=1; clear_flags alone next cycle -> both flags 0, err_count=0.
- With CNT_W=2, push 5 error entries -> err_count saturates at 3. Assert rst_n=0 for one cycle with 3 entries queued -> occupancy=0, out_valid=0, in_ready=1, flags and err_count=0.
